// File: rtl/rr_requester_cluster.sv
// ============================================================================
//  Module   : rr_requester_cluster
//  Purpose  : Four per-channel FIFOs that raise requests to an external
//             4-way round-robin arbiter and drain the granted channel into a
//             single registered output beat (valid/ready handshake).
//             Flags multi-bit grants (sticky) and counts stale grants.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_requester_cluster #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      in_valid,
  input  logic [4*DW-1:0] in_data,
  output logic [3:0]      in_ready,
  output logic [3:0]      REQ,
  input  logic [3:0]      GNT,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [1:0]      out_id,
  input  logic            out_ready,
  output logic            err_multi_gnt,
  output logic [7:0]      stale_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] c_full = CW'(DEPTH);

  logic          w_load_ok;
  logic          w_onehot;
  logic          w_multi;
  logic          w_stale;
  logic [3:0]    w_pop;
  logic [DW-1:0] w_head [4];
  logic          w_pop_any;
  logic [1:0]    w_pop_id;
  logic [DW-1:0] w_pop_data;

  // The output register may take a new beat when empty or being drained.
  assign w_load_ok = !out_valid || out_ready;
  assign w_onehot  = (GNT != 4'd0) && ((GNT & (GNT - 4'd1)) == 4'd0);
  assign w_multi   = (GNT != 4'd0) && !w_onehot;
  // A one-hot grant landing on an empty channel: REQ is low for that bit.
  assign w_stale   = w_onehot && ((GNT & REQ) == 4'd0);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ch
      logic [DW-1:0] r_mem [DEPTH];
      logic [AW-1:0] r_wr_ptr;
      logic [AW-1:0] r_rd_ptr;
      logic [CW-1:0] r_count;
      logic          w_push;

      assign in_ready[gi] = (r_count != c_full);
      assign REQ[gi]      = (r_count != '0);
      assign w_push       = in_valid[gi] && in_ready[gi];
      assign w_pop[gi]    = (GNT == (4'b0001 << gi)) && REQ[gi] && w_load_ok;
      assign w_head[gi]   = r_mem[r_rd_ptr];

      // Storage write; contents are don't-care until pushed, so no reset.
      always_ff @(posedge clk) begin
        if (w_push) begin
          r_mem[r_wr_ptr] <= in_data[gi*DW +: DW];
        end
      end

      // Pointers wrap naturally since DEPTH is a power of two.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_push)    r_wr_ptr <= r_wr_ptr + AW'(1);
          if (w_pop[gi]) r_rd_ptr <= r_rd_ptr + AW'(1);
          case ({w_push, w_pop[gi]})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
          endcase
        end
      end
    end
  endgenerate

  // Select the head word and index of the (at most one) popping channel.
  always_comb begin
    w_pop_any  = 1'b0;
    w_pop_id   = 2'd0;
    w_pop_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (w_pop[i]) begin
        w_pop_any  = 1'b1;
        w_pop_id   = 2'(i);
        w_pop_data = w_head[i];
      end
    end
  end

  // Output beat register: load on pop, drain when accepted, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= 2'd0;
    end else if (w_pop_any) begin
      out_valid <= 1'b1;
      out_data  <= w_pop_data;
      out_id    <= w_pop_id;
    end else if (w_load_ok) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky multi-grant error and saturating stale-grant counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_multi_gnt <= 1'b0;
      stale_cnt     <= 8'd0;
    end else begin
      if (w_multi) err_multi_gnt <= 1'b1;
      if (w_stale && (stale_cnt != 8'hFF)) stale_cnt <= stale_cnt + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_requester_cluster.sv
// ============================================================================
//  Module   : tb_rr_requester_cluster
//  Purpose  : Directed + randomised bench for rr_requester_cluster with a
//             queue-based behavioural model and output-beat scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_requester_cluster;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic            clk;
  logic            rst;
  logic [3:0]      in_valid;
  logic [4*DW-1:0] in_data;
  logic [3:0]      in_ready;
  logic [3:0]      REQ;
  logic [3:0]      GNT;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_id;
  logic            out_ready;
  logic            err_multi_gnt;
  logic [7:0]      stale_cnt;

  rr_requester_cluster #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .REQ(REQ), .GNT(GNT),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .out_ready(out_ready),
    .err_multi_gnt(err_multi_gnt), .stale_cnt(stale_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [DW-1:0] mq [4][$];
  logic [9:0]    sb [$];
  logic          mv;
  logic [DW-1:0] mdata;
  logic [1:0]    mid;
  logic          merr;
  int            ms;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, then compare at edge+1.
  task automatic cyc(input logic r, input logic [3:0] iv, input logic [31:0] d,
                     input logic [3:0] g, input logic ordy);
    logic       load_ok, onehot, multi, pop, stale;
    int         idx;
    logic [3:0] pushes;
    logic [3:0] mreq, mrdy;
    logic [9:0] e;
    rst = r; in_valid = iv; in_data = d; GNT = g; out_ready = ordy;
    load_ok = !mv || ordy;
    onehot  = (g != 4'd0) && ((g & (g - 4'd1)) == 4'd0);
    multi   = (g != 4'd0) && !onehot;
    idx = 0;
    for (int i = 0; i < 4; i++) if (g[i]) idx = i;
    pop   = onehot && (mq[idx].size() > 0) && load_ok;
    stale = onehot && (mq[idx].size() == 0);
    for (int i = 0; i < 4; i++) pushes[i] = iv[i] && (mq[i].size() < DEPTH);
    if (pop) begin
      e = {idx[1:0], mq[idx].pop_front()};
      sb.push_back(e);
    end
    for (int i = 0; i < 4; i++) if (pushes[i]) mq[i].push_back(d[i*DW +: DW]);
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      sb.delete();
      mv = 1'b0; mdata = '0; mid = 2'd0; merr = 1'b0; ms = 0;
    end else begin
      if (pop) begin
        e = sb.pop_front();
        mv = 1'b1; mdata = e[7:0]; mid = e[9:8];
      end else if (load_ok) begin
        mv = 1'b0;
      end
      if (multi) merr = 1'b1;
      if (stale && ms < 255) ms++;
    end
    for (int i = 0; i < 4; i++) begin
      mreq[i] = mq[i].size() != 0;
      mrdy[i] = mq[i].size() != DEPTH;
    end
    chk("out_valid", out_valid, mv);
    if (mv) begin
      chk("out_data", out_data, mdata);
      chk("out_id", out_id, mid);
    end
    chk("REQ", REQ, mreq);
    chk("in_ready", in_ready, mrdy);
    chk("stale_cnt", stale_cnt, ms);
    chk("err_multi_gnt", err_multi_gnt, merr);
  endtask

  task automatic idle(input logic [3:0] g, input logic ordy);
    cyc(1'b0, 4'd0, 32'd0, g, ordy);
  endtask

  initial begin
    logic [3:0] rg;
    int         rsel;
    mv = 1'b0; mdata = '0; mid = 2'd0; merr = 1'b0; ms = 0;
    rst = 1'b1; in_valid = '0; in_data = '0; GNT = '0; out_ready = 1'b0;

    // Reset state
    cyc(1'b1, 4'd0, 32'd0, 4'd0, 1'b0);
    chk("rst_in_ready", in_ready, 4'b1111);
    chk("rst_REQ", REQ, 4'b0000);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_id", out_id, 2'd0);

    // Single word through channel 2
    cyc(1'b0, 4'b0100, 32'h00A5_0000, 4'd0, 1'b1);
    chk("a5_REQ", REQ, 4'b0100);
    idle(4'b0100, 1'b1);
    chk("a5_out", {out_valid, out_id, out_data}, {1'b1, 2'd2, 8'hA5});
    chk("a5_REQ_after", REQ, 4'b0000);
    idle(4'd0, 1'b1);

    // Fill channel 0, attempt overflow, drain in order with wrap
    for (int k = 0; k < DEPTH; k++) cyc(1'b0, 4'b0001, 32'h10 + k, 4'd0, 1'b1);
    chk("full_ready0", in_ready[0], 1'b0);
    cyc(1'b0, 4'b0001, 32'hEE, 4'd0, 1'b1);
    for (int k = 0; k < DEPTH; k++) begin
      idle(4'b0001, 1'b1);
      chk("drain_word", out_data, 8'h10 + k);
    end
    cyc(1'b0, 4'b0001, 32'h77, 4'd0, 1'b1);
    cyc(1'b0, 4'b0001, 32'h78, 4'b0001, 1'b1);
    chk("wrap_word0", out_data, 8'h77);
    idle(4'b0001, 1'b1);
    chk("wrap_word1", out_data, 8'h78);
    idle(4'd0, 1'b1);

    // Stale grants and saturation
    cyc(1'b1, 4'd0, 32'd0, 4'd0, 1'b1);
    for (int k = 0; k < 3; k++) idle(4'b1000, 1'b1);
    chk("stale_3", stale_cnt, 8'd3);
    chk("stale_no_beat", out_valid, 1'b0);
    for (int k = 0; k < 300; k++) idle(4'b1000, 1'b1);
    chk("stale_sat", stale_cnt, 8'd255);
    idle(4'd0, 1'b1);
    chk("zero_gnt_not_stale", stale_cnt, 8'd255);

    // Multi-bit grant
    cyc(1'b1, 4'd0, 32'd0, 4'd0, 1'b1);
    cyc(1'b0, 4'b0011, 32'h0000_3C5A, 4'd0, 1'b1);
    idle(4'b0011, 1'b1);
    chk("multi_err", err_multi_gnt, 1'b1);
    chk("multi_no_pop", {out_valid, REQ}, {1'b0, 4'b0011});
    idle(4'b0001, 1'b1);
    chk("multi_sticky", err_multi_gnt, 1'b1);
    cyc(1'b1, 4'd0, 32'd0, 4'd0, 1'b1);
    chk("multi_cleared", err_multi_gnt, 1'b0);

    // Backpressure on the output register
    cyc(1'b0, 4'b0010, 32'h0000_C100, 4'd0, 1'b1);
    cyc(1'b0, 4'b0010, 32'h0000_C200, 4'd0, 1'b1);
    idle(4'b0010, 1'b1);
    idle(4'b0010, 1'b0);
    idle(4'b0010, 1'b0);
    chk("bp_hold", {out_valid, out_data, REQ[1]}, {1'b1, 8'hC1, 1'b1});
    idle(4'b0010, 1'b1);
    chk("bp_release", out_data, 8'hC2);
    idle(4'd0, 1'b1);

    // Reset mid-operation discards queued words
    cyc(1'b0, 4'b0111, 32'h0033_2211, 4'd0, 1'b1);
    cyc(1'b0, 4'b0111, 32'h0066_5544, 4'd0, 1'b1);
    cyc(1'b1, 4'd0, 32'd0, 4'b0001, 1'b1);
    chk("mid_rst", {REQ, in_ready, out_valid}, {4'b0000, 4'b1111, 1'b0});
    cyc(1'b0, 4'b0001, 32'h99, 4'd0, 1'b1);
    idle(4'b0001, 1'b1);
    chk("post_rst_word", out_data, 8'h99);

    // Randomised traffic against the model
    for (int k = 0; k < 400; k++) begin
      rsel = $urandom_range(0, 9);
      if (rsel < 6)      rg = 4'b0001 << $urandom_range(0, 3);
      else if (rsel < 9) rg = 4'd0;
      else               rg = 4'b0110;
      cyc(1'b0, 4'($urandom_range(0, 15)), $urandom, rg, $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rr_requester_cluster.md
RR_REQUESTER_CLUSTER -- requirements
Module: rr_requester_cluster

Interface
REQ-001 Parameter DW, default 8: data word width per requester.
REQ-002 Parameter DEPTH, default 4: per-channel FIFO depth, power of two, at least 2.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  4  per-channel write strobe, bit i = channel i.
REQ-006 in_data  input  4*DW  per-channel write data, channel i at bits [i*DW +: DW].
REQ-007 in_ready  output  4  per-channel FIFO not full, driven from registered count.
REQ-008 REQ  output  4  request vector to the 4-way round-robin arbiter; REQ[i] = channel i FIFO not empty.
REQ-009 GNT  input  4  grant vector from the arbiter; one-hot or zero.
REQ-010 out_valid  output  1  registered output beat valid.
REQ-011 out_data  output  DW  registered output beat data.
REQ-012 out_id  output  2  channel index of the current output beat.
REQ-013 out_ready  input  1  downstream accepts the beat when out_valid and out_ready are both high.
REQ-014 err_multi_gnt  output  1  sticky flag; set when GNT has more than one bit high.
REQ-015 stale_cnt  output  8  saturating count of stale grants.

Function
REQ-016 Each channel SHALL own an independent FIFO with DEPTH entries; its occupancy counter SHALL range 0..DEPTH.
REQ-017 A push to channel i SHALL occur on the clock edge when in_valid[i] and in_ready[i] are both high; in_ready[i] SHALL be low only when count_i equals DEPTH.
REQ-018 REQ[i] SHALL be combinational from count_i != 0; a word pushed at edge t SHALL raise REQ[i] in cycle t+1.
REQ-019 The output register SHALL be able to load when out_valid is low or out_ready is high (load_ok).
REQ-020 A pop of channel i SHALL occur when GNT equals the one-hot value for i, count_i != 0, and load_ok; at that edge out_data <= head_i, out_id <= i, out_valid <= 1.
REQ-021 When load_ok is high and no pop occurs, out_valid SHALL become 0 at the next edge; otherwise out_valid, out_data and out_id SHALL hold.
REQ-022 A stale grant is defined as GNT one-hot with the granted channel's count = 0. It SHALL pop nothing, SHALL NOT change out_* except as REQ-021 requires, and SHALL increment stale_cnt, which saturates at 255.
REQ-023 GNT = 0000 SHALL pop nothing and SHALL NOT count as stale.
REQ-024 GNT with two or more bits set SHALL pop nothing and SHALL set err_multi_gnt until reset.
REQ-025 A simultaneous push and pop on one channel SHALL leave count unchanged and SHALL advance both pointers.
REQ-026 A push while full SHALL be impossible, because in_ready = 0; a push while empty SHALL NOT bypass to the output.
REQ-027 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-028 When a grant arrives and load_ok is low, the pop SHALL be withheld and REQ[i] SHALL remain high.
REQ-029 Pop-to-output latency SHALL be 1 cycle: GNT in cycle t gives out_valid in cycle t+1.

Reset
REQ-030 While rst is high at a clock edge, the block SHALL clear all counts and pointers, out_valid, out_data, out_id, err_multi_gnt and stale_cnt to 0, and SHALL force in_ready = 1111 and REQ = 0000 from the following cycle.
REQ-031 Reset asserted mid-operation SHALL discard all queued words; no beat SHALL issue in the cycle after reset.
REQ-032 FIFO storage contents SHALL NOT require reset.

Verification
REQ-033 Push 0xA5 to channel 2, out_ready = 1, GNT = 0100 one cycle later -> REQ = 0100, then out_valid = 1, out_data = 0xA5, out_id = 2, then REQ = 0000.
REQ-034 Push DEPTH words to channel 0 -> in_ready[0] = 0; a further in_valid[0] is ignored; rotating GNT 0001 pops the words in order with the pointer wrapping.
REQ-035 GNT = 1000 with channel 3 empty for 3 cycles -> no beat and stale_cnt = 3; drive 300 stale cycles -> stale_cnt = 255.
REQ-036 GNT = 0011 -> no pop and err_multi_gnt = 1; it stays 1 after GNT returns to 0001, until rst.
REQ-037 out_ready = 0 with out_valid = 1 and GNT = 0010 on a non-empty channel 1 -> no pop, out_* hold and REQ[1] = 1; release out_ready -> the pop proceeds.
REQ-038 rst pulsed with three channels holding 2 words each -> REQ = 0000, in_ready = 1111, out_valid = 0 on the next cycle.
